// File: rtl/mul_reservation_station.sv
// Multiply reservation station: buffers dispatched ops, snoops the CDB,
// issues ready ops to the multiplier and releases tags on result broadcast.
typedef struct packed {
  logic [2:0] op;
  logic       is_signed;
  logic       oe;
  logic       rc;
} mul_decode_t;

module mul_reservation_station #(
  parameter int RS_ID_WIDTH = 5,
  parameter int RS_DEPTH    = 4,
  parameter int RS_OFFSET   = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   disp_valid,
  output logic                   disp_ready,
  output logic [RS_ID_WIDTH-1:0] disp_rs_id,
  input  logic [4:0]             disp_result_reg_addr,
  input  mul_decode_t            disp_control,
  input  logic                   disp_op1_valid,
  input  logic                   disp_op2_valid,
  input  logic                   disp_xer_valid,
  input  logic [31:0]            disp_op1,
  input  logic [31:0]            disp_op2,
  input  logic [31:0]            disp_xer,
  input  logic [RS_ID_WIDTH-1:0] disp_op1_tag,
  input  logic [RS_ID_WIDTH-1:0] disp_op2_tag,
  input  logic [RS_ID_WIDTH-1:0] disp_xer_tag,
  input  logic                   cdb_valid,
  input  logic [RS_ID_WIDTH-1:0] cdb_rs_id,
  input  logic [31:0]            cdb_result,
  input  logic                   cdb_xer_valid,
  input  logic [31:0]            cdb_xer,
  output logic                   issue_valid,
  input  logic                   issue_ready,
  output logic [RS_ID_WIDTH-1:0] issue_rs_id,
  output logic [4:0]             issue_result_reg_addr,
  output logic [31:0]            issue_op1,
  output logic [31:0]            issue_op2,
  output logic [31:0]            issue_xer,
  output mul_decode_t            issue_control
);
  localparam int IW = RS_ID_WIDTH;

  typedef enum logic [1:0] {
    S_FREE, S_WAIT, S_READY, S_ISSUED
  } state_e;

  typedef struct packed {
    logic          vld;
    logic [IW-1:0] tag;
    logic [31:0]   val;
  } opnd_t;

  typedef struct packed {
    state_e      st;
    logic [4:0]  rd;
    mul_decode_t ctrl;
    opnd_t       op1;
    opnd_t       op2;
    opnd_t       xer;
  } ent_t;

  typedef struct packed {
    logic [IW-1:0] rs_id;
    logic [4:0]    rd;
    mul_decode_t   ctrl;
    logic [31:0]   op1;
    logic [31:0]   op2;
    logic [31:0]   xer;
  } iss_t;

  ent_t ent_q [RS_DEPTH];
  ent_t ent_d [RS_DEPTH];
  iss_t iss_q, iss_d;
  logic iss_vld_q, iss_vld_d;

  logic [RS_DEPTH-1:0] free_oh, rdy_oh;
  logic                free_any, rdy_any;
  logic                disp_fire, iss_load;
  opnd_t               d_op1, d_op2, d_xer;

  assign d_op1 = '{vld: disp_op1_valid, tag: disp_op1_tag, val: disp_op1};
  assign d_op2 = '{vld: disp_op2_valid, tag: disp_op2_tag, val: disp_op2};
  assign d_xer = '{vld: disp_xer_valid, tag: disp_xer_tag, val: disp_xer};

  function automatic opnd_t snoop(
    input opnd_t         o,
    input logic          hit_en,
    input logic [IW-1:0] hit_tag,
    input logic [31:0]   hit_val
  );
    snoop = o;
    if (!o.vld && hit_en && o.tag == hit_tag) begin
      snoop.vld = 1'b1;
      snoop.val = hit_val;
    end
  endfunction

  always_comb begin
    free_any   = 1'b0;
    rdy_any    = 1'b0;
    free_oh    = '0;
    rdy_oh     = '0;
    disp_rs_id = '0;
    for (int i = 0; i < RS_DEPTH; i++) begin
      if (!free_any && ent_q[i].st == S_FREE) begin
        free_any   = 1'b1;
        free_oh[i] = 1'b1;
        disp_rs_id = IW'(RS_OFFSET + i);
      end
      if (!rdy_any && ent_q[i].st == S_READY) begin
        rdy_any   = 1'b1;
        rdy_oh[i] = 1'b1;
      end
    end
  end

  assign disp_ready = free_any;

  always_comb begin
    disp_fire = disp_valid && free_any;
    iss_load  = !iss_vld_q || issue_ready;
    iss_d     = iss_q;
    iss_vld_d = iss_vld_q;
    if (iss_load)
      iss_vld_d = rdy_any;
    for (int i = 0; i < RS_DEPTH; i++) begin
      ent_d[i] = ent_q[i];
      ent_d[i].op1 = snoop(ent_q[i].op1, cdb_valid,
                           cdb_rs_id, cdb_result);
      ent_d[i].op2 = snoop(ent_q[i].op2, cdb_valid,
                           cdb_rs_id, cdb_result);
      ent_d[i].xer = snoop(ent_q[i].xer,
                           cdb_valid && cdb_xer_valid,
                           cdb_rs_id, cdb_xer);
      if (iss_load && rdy_oh[i]) begin
        iss_d.rs_id = IW'(RS_OFFSET + i);
        iss_d.rd    = ent_q[i].rd;
        iss_d.ctrl  = ent_q[i].ctrl;
        iss_d.op1   = ent_q[i].op1.val;
        iss_d.op2   = ent_q[i].op2.val;
        iss_d.xer   = ent_q[i].xer.val;
      end
      unique case (ent_q[i].st)
        S_FREE: begin
          if (disp_fire && free_oh[i]) begin
            ent_d[i].rd   = disp_result_reg_addr;
            ent_d[i].ctrl = disp_control;
            // bypass: a same-cycle CDB hit lands as already valid
            ent_d[i].op1  = snoop(d_op1, cdb_valid,
                                  cdb_rs_id, cdb_result);
            ent_d[i].op2  = snoop(d_op2, cdb_valid,
                                  cdb_rs_id, cdb_result);
            ent_d[i].xer  = snoop(d_xer,
                                  cdb_valid && cdb_xer_valid,
                                  cdb_rs_id, cdb_xer);
            ent_d[i].st   = (ent_d[i].op1.vld &&
                             ent_d[i].op2.vld &&
                             ent_d[i].xer.vld) ?
                            S_READY : S_WAIT;
          end
        end
        S_WAIT: begin
          if (ent_d[i].op1.vld && ent_d[i].op2.vld &&
              ent_d[i].xer.vld)
            ent_d[i].st = S_READY;
        end
        S_READY: begin
          if (iss_load && rdy_oh[i])
            ent_d[i].st = S_ISSUED;
        end
        S_ISSUED: begin
          if (cdb_valid && cdb_rs_id == IW'(RS_OFFSET + i))
            ent_d[i].st = S_FREE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < RS_DEPTH; i++)
        ent_q[i] <= '0;
      iss_q     <= '0;
      iss_vld_q <= 1'b0;
    end else begin
      for (int i = 0; i < RS_DEPTH; i++)
        ent_q[i] <= ent_d[i];
      iss_q     <= iss_d;
      iss_vld_q <= iss_vld_d;
    end
  end

  assign issue_valid           = iss_vld_q;
  assign issue_rs_id           = iss_q.rs_id;
  assign issue_result_reg_addr = iss_q.rd;
  assign issue_op1             = iss_q.op1;
  assign issue_op2             = iss_q.op2;
  assign issue_xer             = iss_q.xer;
  assign issue_control         = iss_q.ctrl;
endmodule
